// File: rtl/div18x18_2c.sv
// Sequential signed divider: one quotient bit per en-cycle, restoring shift/subtract on magnitudes,
// with a final FIX cycle that applies the operand signs and the divide-by-zero result.
module div18x18_2c #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // dividend magnitude, quotient bits shift in from the bottom
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dz_q, dz_d, done_q, done_d;

  // Magnitudes are taken as unsigned WIDTH-bit values, which already covers |-2^(WIDTH-1)|.
  // The shifted partial remainder carries one extra bit for the trial compare.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             keep;

  always_comb begin
    shifted = {rem_q, a_q[WIDTH-1]};
    keep    = shifted >= {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = done_q;

    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH - 1);
            a_d     = A[WIDTH-1] ? -A : A;
            b_d     = B[WIDTH-1] ? -B : B;
            rem_d   = '0;
            qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
            rneg_d  = A[WIDTH-1];
            zero_d  = (B == '0);
          end
        end
        CALC: begin
          // With B=0 every trial "succeeds", so rem ends up holding |A| unchanged.
          rem_d = keep ? diff : shifted[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], keep};
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d = cnt_q - CW'(1);
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          q_d     = zero_q ? '1 : (qneg_q ? -a_q : a_q);
          r_d     = rneg_q ? -rem_q : rem_q;
          dz_d    = zero_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_div18x18_2c.sv
// Bench for div18x18_2c: directed vector table, stall/restart/reset sequences and a random sweep
// against an integer-arithmetic reference model.
module tb_div18x18_2c;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] Q, R;

  int errors = 0;
  int checks = 0;

  div18x18_2c #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: plain signed integer division truncating toward zero, remainder takes dividend sign.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      q = iq[W-1:0]; r = ir[W-1:0]; dz = 1'b0;
    end
  endfunction

  // Issues one operation, optional en stall window and a spurious start while busy.
  // Returns the number of clock edges from acceptance to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len, input int spur_at,
                        output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_low_after_start", {31'd0, done}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (1) begin
      en = !(lat >= stall_at && lat < stall_at + stall_len);
      start = (lat == spur_at);
      if (lat == spur_at) begin A = 18'd7; B = 18'd1; end
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat > 200) begin
        chk("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
    en = 1'b1; start = 1'b0;
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz);
    chk({tag, "_Q"}, 32'(Q), 32'(q));
    chk({tag, "_R"}, 32'(R), 32'(r));
    chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
  endtask

  initial begin
    vec_t vecs[7];
    int lat, seen;
    logic [W-1:0] eq, er;
    logic         edz;

    vecs[0] = '{18'd100,   18'd7,       18'd14,      18'd2,       1'b0};
    vecs[1] = '{18'h3FF9C, 18'd7,       18'h3FFF2,   18'h3FFFE,   1'b0};
    vecs[2] = '{18'd100,   18'h3FFF9,   18'h3FFF2,   18'd2,       1'b0};
    vecs[3] = '{18'h20000, 18'h3FFFF,   18'h20000,   18'd0,       1'b0};
    vecs[4] = '{18'd5,     18'd0,       18'h3FFFF,   18'd5,       1'b1};
    vecs[5] = '{18'h3FFFB, 18'd0,       18'h3FFFF,   18'h3FFFB,   1'b1};
    vecs[6] = '{18'h3FF9C, 18'h3FFF9,   18'd14,      18'h3FFFE,   1'b0};

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1000, 0, 1000, lat);
      chk("vec_latency", 32'(lat), 32'd19);
      check_result("vec", vecs[i].q, vecs[i].r, vecs[i].dz);
      @(posedge clk); #1;
      chk("vec_done_one_cycle", {31'd0, done}, 32'd0);
      check_result("vec_hold", vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // en low for 5 cycles mid-CALC plus a start pulse while busy
    run_op(18'd100, 18'd7, 5, 5, 12, lat);
    chk("stall_latency", 32'(lat), 32'd24);
    check_result("stall", 18'd14, 18'd2, 1'b0);

    // done held while en is low
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("done_held_en_low", {31'd0, done}, 32'd1);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    chk("done_drops_after_en", {31'd0, done}, 32'd0);

    // back-to-back: second start lands in the done cycle of the first
    run_op(18'd100, 18'd7, 1000, 0, 1000, lat);
    run_op(18'd1000, 18'd33, 1000, 0, 1000, lat);
    chk("b2b_latency", 32'(lat), 32'd19);
    check_result("b2b", 18'd30, 18'd10, 1'b0);

    // asynchronous reset mid-operation
    @(negedge clk); A = 18'd100; B = 18'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_Q", 32'(Q), 32'd0);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);
    run_op(18'd100, 18'd7, 1000, 0, 1000, lat);
    chk("post_rst_latency", 32'(lat), 32'd19);
    check_result("post_rst", 18'd14, 18'd2, 1'b0);

    // random sweep, B != 0, with occasional short en stalls
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] ra, rb;
      int st_at, st_len, ia, ib, iq, ir;
      logic [W-1:0] recon;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 4 == 0) rb = W'($urandom_range(1, 40)) ^ {W{rb[0]}};
      if (rb == '0) rb = 18'd1;
      st_at  = $urandom_range(1, 15);
      st_len = $urandom_range(0, 3);
      ref_div(ra, rb, eq, er, edz);
      run_op(ra, rb, st_at, st_len, 1000, lat);
      chk("rnd_latency", 32'(lat), 32'(19 + st_len));
      check_result("rnd", eq, er, edz);
      ia = int'($signed(ra)); ib = int'($signed(rb));
      iq = int'($signed(Q));  ir = int'($signed(R));
      recon = W'(iq * ib + ir);
      chk("rnd_identity", 32'(recon), 32'(ra));
      chk("rnd_rem_bound", 32'((ir < 0 ? -ir : ir) < (ib < 0 ? -ib : ib)), 32'd1);
      chk("rnd_rem_sign", 32'(ir == 0 || ((ir < 0) == (ia < 0))), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
